// File: rtl/dac_spi_tx.sv
// Dual-channel SPI (mode 0) transmitter for a 12-bit dual DAC.
// Each sampling strobe captures both channel words, sends frame A then frame B,
// and finally pulses LDAC low so both DAC outputs update together.
module dac_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2,
  parameter int LDAC_WIDTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_sampling,
  input  logic        enableA,
  input  logic        enableB,
  input  logic [11:0] dacA_word,
  input  logic [11:0] dacB_word,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CS_HOLD,
    GAP,
    LDAC
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic             sclk_hi, sclk_hi_next;
  logic             frame_sel, frame_sel_next;
  logic [15:0]      frame_a, frame_a_next;
  logic [15:0]      frame_b, frame_b_next;
  logic             done_q, done_next;
  logic             overrun_q, overrun_next;
  logic [15:0]      cur_frame;

  // A disabled channel gets the shutdown form of the frame with its data zeroed.
  function automatic logic [15:0] build_frame(input logic ch, input logic en,
                                              input logic [11:0] data);
    return {ch, 1'b1, 1'b1, en, (en ? data : 12'h000)};
  endfunction

  // Next-state logic: one shared counter times every SCLK phase, hold, gap and LDAC interval.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    bit_cnt_next   = bit_cnt;
    sclk_hi_next   = sclk_hi;
    frame_sel_next = frame_sel;
    frame_a_next   = frame_a;
    frame_b_next   = frame_b;
    done_next      = 1'b0;
    overrun_next   = overrun_q;

    case (state)
      IDLE: begin
        if (clk_sampling) begin
          frame_a_next   = build_frame(1'b0, enableA, dacA_word);
          frame_b_next   = build_frame(1'b1, enableB, dacB_word);
          state_next     = SHIFT;
          cnt_next       = '0;
          bit_cnt_next   = 4'd15;
          sclk_hi_next   = 1'b0;
          frame_sel_next = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_next = '0;
          if (!sclk_hi) begin
            sclk_hi_next = 1'b1;
          end else begin
            sclk_hi_next = 1'b0;
            if (bit_cnt == 4'd0) begin
              state_next = CS_HOLD;
            end else begin
              bit_cnt_next = bit_cnt - 4'd1;
            end
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      CS_HOLD: begin
        if (cnt == DIV_LAST) begin
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_next = '0;
          if (!frame_sel) begin
            frame_sel_next = 1'b1;
            bit_cnt_next   = 4'd15;
            sclk_hi_next   = 1'b0;
            state_next     = SHIFT;
          end else begin
            state_next = LDAC;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      LDAC: begin
        if (cnt == LDAC_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (clk_sampling && (state != IDLE)) begin
      overrun_next = 1'b1;
    end
  end

  // State register; synchronous reset abandons any partial transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= 4'd15;
      sclk_hi   <= 1'b0;
      frame_sel <= 1'b0;
      frame_a   <= '0;
      frame_b   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_cnt   <= bit_cnt_next;
      sclk_hi   <= sclk_hi_next;
      frame_sel <= frame_sel_next;
      frame_a   <= frame_a_next;
      frame_b   <= frame_b_next;
      done_q    <= done_next;
      overrun_q <= overrun_next;
    end
  end

  // Outputs decode straight from registers; mosi only moves when bit_cnt does (on SCLK fall).
  always_comb begin
    cur_frame  = frame_sel ? frame_b : frame_a;
    spi_sclk   = (state == SHIFT) && sclk_hi;
    spi_cs_n   = !((state == SHIFT) || (state == CS_HOLD));
    spi_mosi   = ((state == SHIFT) || (state == CS_HOLD)) ? cur_frame[bit_cnt] : 1'b0;
    dac_ldac_n = (state != LDAC);
    busy       = (state != IDLE);
    done       = done_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed testbench for dac_spi_tx: default-parameter and minimum-parameter instances.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stb0 = 1'b0, stb1 = 1'b0;
  logic        enableA = 1'b1, enableB = 1'b1;
  logic [11:0] dacA_word = '0, dacB_word = '0;

  logic sclk0, mosi0, cs0, ldac0, busy0, done0, ovr0;
  logic sclk1, mosi1, cs1, ldac1, busy1, done1, ovr1;

  dac_spi_tx u_dut0 (
    .clk(clk), .reset(reset), .clk_sampling(stb0), .enableA(enableA), .enableB(enableB),
    .dacA_word(dacA_word), .dacB_word(dacB_word), .spi_sclk(sclk0), .spi_mosi(mosi0),
    .spi_cs_n(cs0), .dac_ldac_n(ldac0), .busy(busy0), .done(done0), .overrun(ovr0)
  );

  dac_spi_tx #(.CLK_DIV(1), .CS_GAP(1), .LDAC_WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .clk_sampling(stb1), .enableA(enableA), .enableB(enableB),
    .dacA_word(dacA_word), .dacB_word(dacB_word), .spi_sclk(sclk1), .spi_mosi(mosi1),
    .spi_cs_n(cs1), .dac_ldac_n(ldac1), .busy(busy1), .done(done1), .overrun(ovr1)
  );

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int t0 = 0;

  logic msel = 1'b0;
  logic m_sclk, m_mosi, m_cs, m_ldac, m_busy, m_done;
  logic p_sclk = 1'b0, p_mosi = 1'b0, p_cs = 1'b1, p_ldac = 1'b1;

  logic [15:0] shreg;
  logic [15:0] frames[$];
  int fbits[$];
  int nbits, first_rise, second_rise, first_csfall, second_csfall, first_csrise;
  int last_fall, hold_len, ldac_pulses, ldac_cycles, busy_cycles, done_rel, glitches;
  int mon_rel;

  // 100 MHz clock and a free-running cycle count.
  always #5 clk = ~clk;

  // Cycle counter used to express timing relative to the strobe.
  always @(posedge clk) cyc++;

  // Watch whichever instance is currently under test.
  always_comb begin
    m_sclk = msel ? sclk1 : sclk0;
    m_mosi = msel ? mosi1 : mosi0;
    m_cs   = msel ? cs1   : cs0;
    m_ldac = msel ? ldac1 : ldac0;
    m_busy = msel ? busy1 : busy0;
    m_done = msel ? done1 : done0;
  end

  // Passive SPI receiver and timing recorder, sampling on the falling clk edge.
  always @(negedge clk) begin
    mon_rel = cyc - t0;
    if (!p_sclk && m_sclk) begin
      shreg = {shreg[14:0], m_mosi};
      nbits++;
      if (first_rise < 0) first_rise = mon_rel;
      else if (second_rise < 0) second_rise = mon_rel;
    end
    if (p_sclk && !m_sclk) last_fall = mon_rel;
    if (p_cs && !m_cs) begin
      if (first_csfall < 0) first_csfall = mon_rel;
      else if (second_csfall < 0) second_csfall = mon_rel;
    end
    if (!p_cs && m_cs) begin
      frames.push_back(shreg);
      fbits.push_back(nbits);
      nbits = 0;
      if (first_csrise < 0) begin
        first_csrise = mon_rel;
        hold_len = mon_rel - last_fall;
      end
    end
    if (p_ldac && !m_ldac) ldac_pulses++;
    if (!m_ldac) ldac_cycles++;
    if (m_busy) busy_cycles++;
    if (m_done && done_rel < 0) done_rel = mon_rel;
    if ((m_mosi !== p_mosi) && !m_cs && !(p_sclk && !m_sclk) && !(p_cs && !m_cs)) glitches++;
    p_sclk = m_sclk;
    p_mosi = m_mosi;
    p_cs   = m_cs;
    p_ldac = m_ldac;
  end

  task automatic clear_mon();
    frames.delete();
    fbits.delete();
    shreg = '0; nbits = 0;
    first_rise = -1; second_rise = -1; first_csfall = -1; second_csfall = -1;
    first_csrise = -1; last_fall = -1; hold_len = -1;
    ldac_pulses = 0; ldac_cycles = 0; busy_cycles = 0; done_rel = -1; glitches = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic int rel_now();
    return cyc - t0;
  endfunction

  task automatic wait_rel(input int r);
    while (rel_now() < r) tick(1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_rel < 0 && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  function automatic logic [15:0] frame_at(input int i);
    return (frames.size() > i) ? frames[i] : 16'hxxxx;
  endfunction

  function automatic int bits_at(input int i);
    return (fbits.size() > i) ? fbits[i] : -1;
  endfunction

  // Pulse the strobe for one clk; optionally make that capture edge the start of cycle 1.
  task automatic applyStimulus(input logic which, input logic set_t0);
    if (which) stb1 = 1'b1; else stb0 = 1'b1;
    @(posedge clk);
    #1;
    if (set_t0) t0 = cyc - 1;
    stb0 = 1'b0;
    stb1 = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear_mon();

    // Reset values on both instances
    tick(3);
    checkOutput("reset_outputs_0", {25'd0, sclk0, mosi0, cs0, ldac0, busy0, done0, ovr0}, 32'b0011000);
    checkOutput("reset_outputs_1", {25'd0, sclk1, mosi1, cs1, ldac1, busy1, done1, ovr1}, 32'b0011000);
    reset = 1'b0;
    tick(2);

    // Basic transfer, default parameters
    msel = 1'b0;
    dacA_word = 12'hABC; dacB_word = 12'h123; enableA = 1'b1; enableB = 1'b1;
    clear_mon();
    applyStimulus(1'b0, 1'b1);
    wait_done(400);
    checkOutput("t1_frame_count", frames.size(), 2);
    checkOutput("t1_frame_a", frame_at(0), 16'h7ABC);
    checkOutput("t1_frame_b", frame_at(1), 16'hF123);
    checkOutput("t1_bits_a", bits_at(0), 16);
    checkOutput("t1_bits_b", bits_at(1), 16);
    checkOutput("t1_cs_fall", first_csfall, 1);
    checkOutput("t1_first_rise", first_rise, 5);
    checkOutput("t1_sclk_period", second_rise - first_rise, 8);
    checkOutput("t1_cs_hold", hold_len, 4);
    checkOutput("t1_gap", second_csfall - first_csrise, 2);
    checkOutput("t1_ldac_pulses", ldac_pulses, 1);
    checkOutput("t1_ldac_width", ldac_cycles, 2);
    checkOutput("t1_busy_len", busy_cycles, 270);
    checkOutput("t1_done_clk", done_rel, 271);
    checkOutput("t1_mosi_stable", glitches, 0);
    checkOutput("t1_done_high", done0, 1'b1);
    checkOutput("t1_overrun", ovr0, 1'b0);
    tick(1);
    checkOutput("t1_done_one_clk", done0, 1'b0);

    // Disabled channel B becomes a shutdown frame
    enableB = 1'b0; dacB_word = 12'hFFF;
    clear_mon();
    applyStimulus(1'b0, 1'b1);
    wait_done(400);
    checkOutput("t2_frame_a", frame_at(0), 16'h7ABC);
    checkOutput("t2_frame_b", frame_at(1), 16'hE000);

    // Disabled channel A
    enableA = 1'b0; dacA_word = 12'hFFF; enableB = 1'b1; dacB_word = 12'h123;
    clear_mon();
    tick(1);
    applyStimulus(1'b0, 1'b1);
    wait_done(400);
    checkOutput("t2_frame_a_off", frame_at(0), 16'h6000);
    checkOutput("t2_frame_b_on", frame_at(1), 16'hF123);

    // Input change and second strobe during a transfer
    enableA = 1'b1; dacA_word = 12'hABC;
    clear_mon();
    tick(1);
    applyStimulus(1'b0, 1'b1);
    wait_rel(10);
    dacA_word = 12'h555;
    wait_rel(100);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_overrun_set", ovr0, 1'b1);
    checkOutput("t3_still_busy", busy0, 1'b1);
    wait_done(400);
    checkOutput("t3_frame_a_captured", frame_at(0), 16'h7ABC);
    checkOutput("t3_frame_b", frame_at(1), 16'hF123);
    checkOutput("t3_busy_len", busy_cycles, 270);
    checkOutput("t3_done_clk", done_rel, 271);
    tick(300);
    checkOutput("t3_frame_count", frames.size(), 2);
    checkOutput("t3_overrun_sticky", ovr0, 1'b1);

    // Reset in the middle of frame A
    dacA_word = 12'hABC;
    clear_mon();
    applyStimulus(1'b0, 1'b1);
    wait_rel(50);
    reset = 1'b1;
    tick(1);
    checkOutput("t4_rst_clk", rel_now(), 51);
    checkOutput("t4_cs_n", cs0, 1'b1);
    checkOutput("t4_sclk", sclk0, 1'b0);
    checkOutput("t4_busy", busy0, 1'b0);
    checkOutput("t4_overrun_cleared", ovr0, 1'b0);
    reset = 1'b0;
    tick(300);
    checkOutput("t4_no_ldac", ldac_pulses, 0);
    checkOutput("t4_no_done", done_rel, -1);
    dacA_word = 12'h0FF; dacB_word = 12'hF00;
    clear_mon();
    applyStimulus(1'b0, 1'b1);
    wait_done(400);
    checkOutput("t4_clean_frame_a", frame_at(0), 16'h70FF);
    checkOutput("t4_clean_frame_b", frame_at(1), 16'hFF00);
    checkOutput("t4_clean_busy", busy_cycles, 270);
    checkOutput("t4_clean_ldac", ldac_pulses, 1);

    // Minimum parameters on the second instance
    msel = 1'b1;
    dacA_word = 12'hABC; dacB_word = 12'h123;
    tick(2);
    clear_mon();
    applyStimulus(1'b1, 1'b1);
    wait_done(200);
    checkOutput("t5_frame_a", frame_at(0), 16'h7ABC);
    checkOutput("t5_frame_b", frame_at(1), 16'hF123);
    checkOutput("t5_first_rise", first_rise, 2);
    checkOutput("t5_cs_hold", hold_len, 1);
    checkOutput("t5_gap", second_csfall - first_csrise, 1);
    checkOutput("t5_ldac_width", ldac_cycles, 1);
    checkOutput("t5_busy_len", busy_cycles, 69);
    checkOutput("t5_done_clk", done_rel, 70);
    checkOutput("t5_mosi_stable", glitches, 0);

    // Strobe on the done cycle is accepted without overrun
    checkOutput("t6_done_now", done1, 1'b1);
    clear_mon();
    applyStimulus(1'b1, 1'b1);
    checkOutput("t6_busy_restart", busy1, 1'b1);
    checkOutput("t6_no_overrun", ovr1, 1'b0);
    wait_done(200);
    checkOutput("t6_frame_count", frames.size(), 2);
    checkOutput("t6_frame_b", frame_at(1), 16'hF123);
    checkOutput("t6_done_clk", done_rel, 70);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
